// File: rtl/rr_burst_scheduler_if.sv
// Requester-side and downstream-side signals of the round-robin burst scheduler.
// The scheduler binds to the slave modport; the requesters/downstream drive the master side.
interface rr_burst_scheduler_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ-1:0]            req_last_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic                          out_valid_o;
  logic [DATA_WIDTH-1:0]         out_data_o;
  logic                          out_last_o;
  logic [IDW-1:0]                out_id_o;
  logic                          out_ready_i;
  logic [NUM_REQ-1:0]            gnt_o;
  logic                          timeout_o;

  modport master (
    output req_valid_i, req_last_i, req_data_i, out_ready_i,
    input  req_ready_o, out_valid_o, out_data_o, out_last_o, out_id_o, gnt_o, timeout_o
  );

  modport slave (
    input  req_valid_i, req_last_i, req_data_i, out_ready_i,
    output req_ready_o, out_valid_o, out_data_o, out_last_o, out_id_o, gnt_o, timeout_o
  );
endinterface

// File: rtl/rr_burst_scheduler.sv
// Round-robin burst scheduler: one owner holds the downstream port for a whole burst,
// with a 1-cycle arbitration bubble and a stall watchdog that frees a silent owner.
module rr_burst_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 64,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  rr_burst_scheduler_if.slave bus
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW  = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           timeout_q, timeout_d;

  logic [IDW-1:0]        win;
  logic                  win_vld;
  logic [IDW-1:0]        owner_inc;
  logic                  own_vld;
  logic                  own_last;
  logic [NUM_REQ-1:0]    rdy;
  logic [NUM_REQ-1:0]    gnt;
  logic                  ovld;
  logic                  olast;
  logic [DATA_WIDTH-1:0] odata;
  logic [IDW-1:0]        oid;

  // Rotating first-set search starting at ptr; modulo keeps non-power-of-two counts legal.
  always_comb begin
    int idx;
    idx     = 0;
    win     = ptr_q;
    win_vld = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!win_vld && bus.req_valid_i[IDW'(idx)]) begin
        win_vld = 1'b1;
        win     = IDW'(idx);
      end
    end
  end

  assign owner_inc = IDW'((int'(owner_q) + 1) % NUM_REQ);
  assign own_vld   = bus.req_valid_i[owner_q];
  assign own_last  = bus.req_last_i[owner_q];

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    rdy       = '0;
    gnt       = '0;
    ovld      = 1'b0;
    olast     = 1'b0;
    odata     = '0;
    oid       = '0;

    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          owner_d = win;
          state_d = BUSY;
          cnt_d   = '0;
        end
      end

      BUSY: begin
        ovld         = own_vld;
        olast        = own_last & own_vld;
        oid          = owner_q;
        gnt[owner_q] = 1'b1;
        rdy[owner_q] = bus.out_ready_i;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (owner_q == IDW'(i)) odata = bus.req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        end

        // Backpressure (valid high, ready low) clears the watchdog just like a transfer.
        if (own_vld && own_last && bus.out_ready_i) begin
          state_d = IDLE;
          ptr_d   = owner_inc;
          cnt_d   = '0;
        end else if (!own_vld) begin
          if (cnt_q >= CW'(IDLE_TIMEOUT - 1)) begin
            state_d   = IDLE;
            ptr_d     = owner_inc;
            cnt_d     = '0;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.req_ready_o = rdy;
  assign bus.gnt_o       = gnt;
  assign bus.out_valid_o = ovld;
  assign bus.out_last_o  = olast;
  assign bus.out_data_o  = odata;
  assign bus.out_id_o    = oid;
  assign bus.timeout_o   = timeout_q;

endmodule

// File: tb/tb_rr_burst_scheduler.sv
// Directed scenarios followed by a randomized run, all checked against a burst-level
// reference model of the round-robin scheduler.
module tb_rr_burst_scheduler;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int T  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_burst_scheduler_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

  rr_burst_scheduler #(.NUM_REQ(N), .DATA_WIDTH(DW), .IDLE_TIMEOUT(T)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  logic [N-1:0]  v;
  logic [N-1:0]  l;
  logic [DW-1:0] dat [N];
  logic          rdy;

  assign bus.req_valid_i = v;
  assign bus.req_last_i  = l;
  assign bus.out_ready_i = rdy;
  for (genvar g = 0; g < N; g++) begin : g_pack
    assign bus.req_data_i[g*DW +: DW] = dat[g];
  end

  int total = 0;
  int bad   = 0;

  // Model: owner is -1 when nobody holds the port; idle_run counts silent owner cycles.
  int m_owner;
  int m_ptr;
  int m_idle_run;
  bit m_to;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [N-1:0]  e_rdy;
    logic [N-1:0]  e_gnt;
    logic          e_vld;
    logic          e_last;
    logic [DW-1:0] e_data;
    int            e_id;
    e_rdy  = '0;
    e_gnt  = '0;
    e_vld  = 1'b0;
    e_last = 1'b0;
    e_data = '0;
    e_id   = 0;
    if (m_owner >= 0) begin
      e_vld          = v[m_owner];
      e_last         = v[m_owner] & l[m_owner];
      e_data         = dat[m_owner];
      e_rdy[m_owner] = rdy;
      e_gnt[m_owner] = 1'b1;
      e_id           = m_owner;
    end
    chk("m_ready",   64'(bus.req_ready_o), 64'(e_rdy));
    chk("m_gnt",     64'(bus.gnt_o),       64'(e_gnt));
    chk("m_valid",   64'(bus.out_valid_o), 64'(e_vld));
    chk("m_last",    64'(bus.out_last_o),  64'(e_last));
    chk("m_data",    64'(bus.out_data_o),  64'(e_data));
    chk("m_id",      64'(bus.out_id_o),    64'(e_id));
    chk("m_timeout", 64'(bus.timeout_o),   64'(m_to));
  endtask

  task automatic model_step();
    if (rst) begin
      m_owner    = -1;
      m_ptr      = 0;
      m_idle_run = 0;
      m_to       = 1'b0;
      return;
    end
    m_to = 1'b0;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (v[c]) begin
          m_owner    = c;
          m_idle_run = 0;
          break;
        end
      end
    end else if (v[m_owner]) begin
      m_idle_run = 0;
      if (rdy && l[m_owner]) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end else begin
      m_idle_run++;
      if (m_idle_run == T) begin
        m_to       = 1'b1;
        m_ptr      = (m_owner + 1) % N;
        m_owner    = -1;
        m_idle_run = 0;
      end
    end
  endtask

  task automatic tick();
    #1;
    check_model();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bit pat [12];
    int beat;
    rst = 1'b1;
    v   = '0;
    l   = '0;
    rdy = 1'b0;
    for (int i = 0; i < N; i++) dat[i] = '0;
    @(posedge clk);
    model_step();
    @(negedge clk);

    // Reset state
    #1;
    chk("rst_gnt",     64'(bus.gnt_o),       64'd0);
    chk("rst_ready",   64'(bus.req_ready_o), 64'd0);
    chk("rst_valid",   64'(bus.out_valid_o), 64'd0);
    chk("rst_last",    64'(bus.out_last_o),  64'd0);
    chk("rst_id",      64'(bus.out_id_o),    64'd0);
    chk("rst_data",    64'(bus.out_data_o),  64'd0);
    chk("rst_timeout", 64'(bus.timeout_o),   64'd0);
    tick();
    rst = 1'b0;

    // Requester 1, 3-beat burst
    rdy = 1'b1; v[1] = 1'b1; dat[1] = 32'hA0;
    tick();
    #1;
    chk("b1_gnt",  64'(bus.gnt_o),      64'b0010);
    chk("b1_id",   64'(bus.out_id_o),   64'd1);
    chk("b1_d0",   64'(bus.out_data_o), 64'hA0);
    tick();
    dat[1] = 32'hA1;
    #1; chk("b1_d1", 64'(bus.out_data_o), 64'hA1);
    tick();
    dat[1] = 32'hA2; l[1] = 1'b1;
    #1;
    chk("b1_d2",   64'(bus.out_data_o), 64'hA2);
    chk("b1_last", 64'(bus.out_last_o), 64'd1);
    tick();
    v = '0; l = '0;
    #1; chk("b1_release", 64'(bus.gnt_o), 64'd0);
    tick();
    // Pointer now at 2: requesters 0,1,2 all valid, 2 must win
    v = 4'b0111; l = 4'b0111;
    tick();
    #1; chk("ptr2_id", 64'(bus.out_id_o), 64'd2);
    tick();
    v = '0; l = '0;
    tick();

    // All four requesters, single-beat bursts from ptr=0
    do_reset();
    v = 4'hF; l = 4'hF; rdy = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("rr_gnt", 64'(bus.gnt_o), (c % 2 == 1) ? (64'd1 << ((c / 2) % 4)) : 64'd0);
      chk("rr_onehot_rdy", 64'($countones(bus.req_ready_o) <= 1), 64'd1);
      tick();
    end
    v = '0; l = '0;
    tick();

    // Wrap priority: ptr=3, requesters 0 and 2 -> 0 then 2
    do_reset();
    v = 4'b0100; l = 4'b0100;
    tick();
    tick();
    v = 4'b0101; l = 4'b0101;
    #1; chk("wrap_bubble", 64'(bus.gnt_o), 64'd0);
    tick();
    #1; chk("wrap_first", 64'(bus.out_id_o), 64'd0);
    tick();
    tick();
    #1; chk("wrap_second", 64'(bus.out_id_o), 64'd2);
    tick();
    v = '0; l = '0;
    tick();

    // Backpressure on owner 2 with a stall longer than the watchdog limit
    do_reset();
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    beat = 0;
    rdy = 1'b0; v[2] = 1'b1; dat[2] = 32'hB0;
    tick();
    for (int p = 0; p < 12; p++) begin
      rdy    = pat[p];
      l[2]   = (beat == 3);
      dat[2] = 32'hB0 + 32'(beat);
      #1;
      chk("bp_ready2",  64'(bus.req_ready_o[2]), 64'(pat[p]));
      chk("bp_timeout", 64'(bus.timeout_o),      64'd0);
      chk("bp_data",    64'(bus.out_data_o),     64'hB0 + 64'(beat));
      tick();
      if (pat[p]) beat++;
    end
    v = '0; l = '0;
    #1; chk("bp_done", 64'(bus.gnt_o), 64'd0);
    tick();

    // Watchdog: owner 0 sends one non-last beat then goes silent; requester 1 waits
    do_reset();
    rdy = 1'b1; v = 4'b0001; l = 4'b0000; dat[0] = 32'hC0;
    tick();
    tick();
    v = 4'b0010; l = 4'b0010; dat[1] = 32'hC1;
    for (int i = 0; i < T; i++) begin
      #1;
      chk("wd_no_pulse", 64'(bus.timeout_o), 64'd0);
      chk("wd_held",     64'(bus.gnt_o),     64'b0001);
      tick();
    end
    #1;
    chk("wd_pulse", 64'(bus.timeout_o), 64'd1);
    chk("wd_idle",  64'(bus.gnt_o),     64'd0);
    tick();
    #1;
    chk("wd_pulse_end", 64'(bus.timeout_o), 64'd0);
    chk("wd_next_gnt",  64'(bus.gnt_o),     64'b0010);
    tick();
    v = '0; l = '0;
    tick();

    // Reset mid-burst: owner 3 on beat 2 of 5
    do_reset();
    v = 4'b1000; l = '0; dat[3] = 32'hE0;
    tick();
    tick();
    dat[3] = 32'hE1;
    #1; chk("mr_owner", 64'(bus.out_id_o), 64'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    v = 4'b1001; l = 4'b1001; dat[0] = 32'hF0;
    #1;
    chk("mr_gnt",   64'(bus.gnt_o),       64'd0);
    chk("mr_valid", 64'(bus.out_valid_o), 64'd0);
    chk("mr_data",  64'(bus.out_data_o),  64'd0);
    chk("mr_id",    64'(bus.out_id_o),    64'd0);
    tick();
    #1; chk("mr_regrant", 64'(bus.gnt_o), 64'b0001);
    tick();
    v = '0; l = '0;
    tick();

    // Randomized traffic with quiet phases to exercise the watchdog
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ((c / 64) % 4 == 3) v[i] = ($urandom_range(0, 9) < 2);
        else                   v[i] = ($urandom_range(0, 9) < 7);
        l[i]   = ($urandom_range(0, 3) == 0);
        dat[i] = $urandom;
      end
      rdy = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
